seq_stage_ctrl: RTL and testbench

Multi-cycle stage sequencer for the Y86-64 SEQ datapath. Drives fetch, decode, execute, memory, write-back and PC-update strobes one stage per cycle, skips stages the current icode does not need, runs a request/acknowledge handshake with data memory, and maintains the processor status code (AOK/HLT/ADR/INS). Sits above the stage modules (fetch, decode/register file, ALU, memory) and is the only source of their enables.

---
 rtl/seq_stage_ctrl.sv | 141 ++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_stage_ctrl.sv
// Stage sequencer for the Y86-64 SEQ datapath: one stage strobe per cycle,
// icode-based stage skipping, data-memory handshake and processor status.
module seq_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ack,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_update_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // state     | meaning
  // IDLE      | waiting for start
  // FETCH     | instruction fetch, icode latched on exit
  // DECODE    | register read, halt/illegal-opcode detection
  // EXECUTE   | ALU, chooses next stage from icode
  // MEMORY    | data-memory request until ack, fault or timeout
  // WRITEBACK | register write
  // PCUPD     | PC update, instruction retired
  // HALT      | terminal until reset
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        state, state_nx;
  logic [2:0]    stat_nx;
  logic [3:0]    icode_q;
  logic [WW-1:0] wait_cnt;

  always_comb begin
    state_nx = state;
    stat_nx  = stat;
    case (state)
      IDLE:      if (start) state_nx = FETCH;
      FETCH: begin
        if (imem_error) begin
          state_nx = HALT;
          stat_nx  = STAT_ADR;
        end else begin
          state_nx = DECODE;
        end
      end
      DECODE: begin
        if (icode_q == 4'h0) begin
          state_nx = HALT;
          stat_nx  = STAT_HLT;
        end else if (icode_q > 4'hB) begin
          state_nx = HALT;
          stat_nx  = STAT_INS;
        end else begin
          state_nx = EXECUTE;
        end
      end
      EXECUTE: begin
        case (icode_q)
          4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: state_nx = MEMORY;
          4'h1, 4'h7:                         state_nx = PCUPD;
          default:                            state_nx = WRITEBACK;
        endcase
      end
      // ack beats a timeout landing in the same cycle
      MEMORY: begin
        if (mem_ack) begin
          if (dmem_error) begin
            state_nx = HALT;
            stat_nx  = STAT_ADR;
          end else begin
            state_nx = (icode_q == 4'h4) ? PCUPD : WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = HALT;
          stat_nx  = STAT_ADR;
        end
      end
      WRITEBACK: state_nx = PCUPD;
      PCUPD:     state_nx = step_mode ? IDLE : FETCH;
      HALT:      state_nx = HALT;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      stat         <= STAT_AOK;
      icode_q      <= 4'h0;
      wait_cnt     <= '0;
      instr_count  <= '0;
      fetch_en     <= 1'b0;
      decode_en    <= 1'b0;
      execute_en   <= 1'b0;
      memory_en    <= 1'b0;
      writeback_en <= 1'b0;
      pc_update_en <= 1'b0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_nx;
      stat         <= stat_nx;
      fetch_en     <= (state_nx == FETCH);
      decode_en    <= (state_nx == DECODE);
      execute_en   <= (state_nx == EXECUTE);
      memory_en    <= (state_nx == MEMORY);
      writeback_en <= (state_nx == WRITEBACK);
      pc_update_en <= (state_nx == PCUPD);
      mem_req      <= (state_nx == MEMORY);
      busy         <= (state_nx != IDLE) && (state_nx != HALT);
      halted       <= (state_nx == HALT);
      if (state == FETCH && !imem_error) icode_q <= icode;
      // held at zero outside MEMORY so every entry starts a fresh wait
      wait_cnt <= (state == MEMORY && !mem_ack) ? wait_cnt + 1'b1 : '0;
      if (state == PCUPD) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: hand-computed stage sequences, faults,
// memory wait/timeout boundaries and asynchronous reset.
module tb_seq_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, step_mode, imem_error, dmem_error, mem_ack;
  logic [3:0]  icode;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en;
  logic        mem_req, busy, halted;
  logic [2:0]  stat;
  logic [31:0] instr_count;
  logic [5:0]  strb;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] S_F = 6'b100000, S_D = 6'b010000, S_E = 6'b001000,
                         S_M = 6'b000100, S_W = 6'b000010, S_P = 6'b000001,
                         S_0 = 6'b000000;

  seq_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .icode(icode),
    .imem_error(imem_error), .dmem_error(dmem_error), .mem_ack(mem_ack),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pc_update_en(pc_update_en),
    .mem_req(mem_req), .stat(stat), .busy(busy), .halted(halted),
    .instr_count(instr_count)
  );

  assign strb = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; icode = 4'h0;
    imem_error = 1'b0; dmem_error = 1'b0; mem_ack = 1'b0;
    #3;
    rst = 1'b0;
  endtask

  // reset, start icode c in free-run and stop on the first MEMORY cycle
  task automatic run_to_mem(input logic [3:0] c);
    do_reset();
    icode = c; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("enter_mem", {58'd0, strb}, {58'd0, S_M});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; icode = 4'h0;
    imem_error = 1'b0; dmem_error = 1'b0; mem_ack = 1'b0;
    #2;
    chk("rst_strb", {58'd0, strb}, 64'd0);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_flags", {61'd0, busy, halted, mem_req}, 64'd0);
    chk("rst_cnt", {32'd0, instr_count}, 64'd0);
    #7;
    rst = 1'b0;

    // OPq free-run: F D E W P then F again with count 1
    icode = 4'h6; start = 1'b1;
    tick(); start = 1'b0;
    chk("op_f", {58'd0, strb}, {58'd0, S_F});
    chk("op_busy", {63'd0, busy}, 64'd1);
    tick(); chk("op_d", {58'd0, strb}, {58'd0, S_D});
    tick(); chk("op_e", {58'd0, strb}, {58'd0, S_E});
    tick(); chk("op_w", {58'd0, strb}, {58'd0, S_W});
    tick(); chk("op_p", {58'd0, strb}, {58'd0, S_P});
    chk("op_cnt_p", {32'd0, instr_count}, 64'd0);
    tick(); chk("op_f2", {58'd0, strb}, {58'd0, S_F});
    chk("op_cnt", {32'd0, instr_count}, 64'd1);

    // mrmovq with ack in the fourth MEMORY cycle: 9 cycles total
    icode = 4'h5;
    tick(); chk("mr_d", {58'd0, strb}, {58'd0, S_D});
    tick(); chk("mr_e", {58'd0, strb}, {58'd0, S_E});
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("mr_m%0d", i), {56'd0, mem_req, memory_en, strb}, {56'd0, 2'b11, S_M});
    end
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("mr_w", {58'd0, strb}, {58'd0, S_W});
    chk("mr_req_off", {63'd0, mem_req}, 64'd0);
    tick(); chk("mr_p", {58'd0, strb}, {58'd0, S_P});
    tick(); chk("mr_f", {58'd0, strb}, {58'd0, S_F});
    chk("mr_cnt", {32'd0, instr_count}, 64'd2);
    chk("mr_stat", {61'd0, stat}, 64'd1);

    // rmmovq skips WRITEBACK
    icode = 4'h4; mem_ack = 1'b1;
    tick(); tick();
    tick(); chk("rm_m", {58'd0, strb}, {58'd0, S_M});
    tick(); mem_ack = 1'b0;
    chk("rm_p", {58'd0, strb}, {58'd0, S_P});

    // nop in step mode, run twice
    do_reset();
    icode = 4'h1; step_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("nop_f", {58'd0, strb}, {58'd0, S_F});
    tick(); chk("nop_d", {58'd0, strb}, {58'd0, S_D});
    tick(); chk("nop_e", {58'd0, strb}, {58'd0, S_E});
    tick(); chk("nop_p", {58'd0, strb}, {58'd0, S_P});
    tick(); chk("nop_idle", {57'd0, busy, strb}, 64'd0);
    chk("nop_cnt1", {32'd0, instr_count}, 64'd1);
    tick(); chk("nop_stay", {57'd0, busy, strb}, 64'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("nop2_f", {58'd0, strb}, {58'd0, S_F});
    tick(); tick(); tick(); tick();
    chk("nop2_idle", {57'd0, busy, strb}, 64'd0);
    chk("nop_cnt2", {32'd0, instr_count}, 64'd2);

    // halt instruction
    do_reset();
    icode = 4'h0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("hlt_d", {58'd0, strb}, {58'd0, S_D});
    tick();
    chk("hlt_halted", {62'd0, halted, busy}, 64'd2);
    chk("hlt_stat", {61'd0, stat}, 64'd2);
    chk("hlt_strb", {58'd0, strb}, 64'd0);
    start = 1'b1; tick(); tick(); start = 1'b0;
    chk("hlt_sticky", {60'd0, halted, stat}, {60'd0, 1'b1, 3'd2});
    chk("hlt_cnt", {32'd0, instr_count}, 64'd0);

    // illegal opcode
    do_reset();
    icode = 4'hC; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("ins", {60'd0, halted, stat}, {60'd0, 1'b1, 3'd4});

    // instruction-memory fault in FETCH
    do_reset();
    icode = 4'h6; imem_error = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("imem_f", {58'd0, strb}, {58'd0, S_F});
    tick(); imem_error = 1'b0;
    chk("imem", {60'd0, halted, stat}, {60'd0, 1'b1, 3'd3});

    // pushq, no ack, stray dmem_error ignored: ADR after 16 MEMORY cycles
    run_to_mem(4'hA);
    dmem_error = 1'b1;
    for (int i = 2; i <= 16; i++) tick();
    chk("to_m16", {57'd0, mem_req, strb}, {57'd0, 1'b1, S_M});
    tick(); dmem_error = 1'b0;
    chk("to_halt", {59'd0, halted, mem_req, stat}, {59'd0, 2'b10, 3'd3});
    chk("to_strb", {58'd0, strb}, 64'd0);

    // ack in the timeout cycle wins
    run_to_mem(4'hA);
    for (int i = 2; i <= 16; i++) tick();
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("ack_wins", {58'd0, strb}, {58'd0, S_W});
    chk("ack_wins_stat", {61'd0, stat}, 64'd1);

    // ack with data-memory error
    run_to_mem(4'h8);
    mem_ack = 1'b1; dmem_error = 1'b1;
    tick(); mem_ack = 1'b0; dmem_error = 1'b0;
    chk("dmem", {60'd0, halted, stat}, {60'd0, 1'b1, 3'd3});

    // async reset mid-MEMORY after one retired nop
    do_reset();
    icode = 4'h1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    icode = 4'h9;
    tick(); chk("ar_cnt", {32'd0, instr_count}, 64'd1);
    tick(); tick(); tick();
    chk("ar_mem", {57'd0, mem_req, strb}, {57'd0, 1'b1, S_M});
    #2; rst = 1'b1; #1;
    chk("ar_strb", {57'd0, mem_req, strb}, 64'd0);
    chk("ar_stat", {61'd0, stat}, 64'd1);
    chk("ar_flags", {62'd0, busy, halted}, 64'd0);
    chk("ar_cnt0", {32'd0, instr_count}, 64'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
